// File: rtl/lcd_timing_gen.sv
// rtl/lcd_timing_gen.sv - pixel clock, X/Y counters and PIPE-delayed HD/VD/DEN for the 800x480 RGB panel
// Optional colour-bar test pattern on R/G/B when LCD_COLOR_BAR_EN is defined.
module lcd_timing_gen #(
  parameter int H_ACT  = 800,
  parameter int H_FP   = 40,
  parameter int H_SYNC = 30,
  parameter int H_BP   = 186,
  parameter int V_ACT  = 480,
  parameter int V_FP   = 22,
  parameter int V_SYNC = 13,
  parameter int V_BP   = 10,
  parameter int PIPE   = 2
) (
  input  logic        CLK,
  input  logic        RST,
  output logic        NCLK,
  output logic        GREST,
  output logic        PIX_TICK,
  output logic [10:0] X,
  output logic [9:0]  Y,
  output logic        SOF,
  output logic        HD,
  output logic        VD,
  output logic        DEN,
  output logic [7:0]  R,
  output logic [7:0]  G,
  output logic [7:0]  B
);
  localparam int PW = PIPE + 1;
  localparam logic [10:0] H_LAST  = 11'(H_ACT + H_FP + H_SYNC + H_BP - 1);
  localparam logic [10:0] H_ACT_W = 11'(H_ACT);
  localparam logic [10:0] HS_BEG  = 11'(H_ACT + H_FP);
  localparam logic [10:0] HS_END  = 11'(H_ACT + H_FP + H_SYNC);
  localparam logic [9:0]  V_LAST  = 10'(V_ACT + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0]  V_ACT_W = 10'(V_ACT);
  localparam logic [9:0]  VS_BEG  = 10'(V_ACT + V_FP);
  localparam logic [9:0]  VS_END  = 10'(V_ACT + V_FP + V_SYNC);

  logic          nclk_q, grest_q, sof_q, sof_d;
  logic [10:0]   x_q, x_d;
  logic [9:0]    y_q, y_d;
  logic          tick;
  logic          hs_new, vs_new, den_new;
  logic [PW-1:0] hs_q, vs_q, den_q;

  assign tick = nclk_q;

  always_comb begin
    x_d   = x_q;
    y_d   = y_q;
    sof_d = 1'b0;
    if (tick) begin
      if (x_q == H_LAST) begin
        x_d   = '0;
        y_d   = (y_q == V_LAST) ? '0 : y_q + 10'd1;
        sof_d = (y_q == V_LAST);
      end else begin
        x_d = x_q + 11'd1;
      end
    end
  end

  // Stage 0 of the delay line is loaded with the decode of the position being entered
  always_comb begin
    hs_new  = !((x_d >= HS_BEG) && (x_d < HS_END));
    vs_new  = !((y_d >= VS_BEG) && (y_d < VS_END));
    den_new = (x_d < H_ACT_W) && (y_d < V_ACT_W);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      nclk_q  <= 1'b0;
      grest_q <= 1'b0;
      sof_q   <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      hs_q    <= '1;
      vs_q    <= '1;
      den_q   <= '0;
    end else begin
      nclk_q  <= ~nclk_q;
      grest_q <= 1'b1;
      sof_q   <= sof_d;
      x_q     <= x_d;
      y_q     <= y_d;
      if (tick) begin
        hs_q  <= (hs_q << 1) | PW'(hs_new);
        vs_q  <= (vs_q << 1) | PW'(vs_new);
        den_q <= (den_q << 1) | PW'(den_new);
      end
    end
  end

  assign NCLK     = nclk_q;
  assign GREST    = grest_q;
  assign PIX_TICK = nclk_q;
  assign X        = x_q;
  assign Y        = y_q;
  assign SOF      = sof_q;
  assign HD       = hs_q[PIPE];
  assign VD       = vs_q[PIPE];
  assign DEN      = den_q[PIPE];

`ifdef LCD_COLOR_BAR_EN
  logic [PW*11-1:0] xd_q;
  logic [10:0]      x_out;
  logic [2:0]       rgb;

  // Bar index b2b1b0 maps to R=!b1, G=!b2, B=!b0 (white, yellow, cyan, ... black)
  function automatic logic [2:0] bar_rgb(input logic [10:0] col);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (col >= 11'(100 * i)) idx = 3'(i);
    end
    return {~idx[1], ~idx[2], ~idx[0]};
  endfunction

  always_ff @(posedge CLK) begin
    if (RST) begin
      xd_q <= '0;
    end else if (tick) begin
      xd_q <= (xd_q << 11) | (PW*11)'(x_d);
    end
  end

  assign x_out = xd_q[PIPE*11 +: 11];
  assign rgb   = bar_rgb(x_out);
  assign R     = {8{DEN & rgb[2]}};
  assign G     = {8{DEN & rgb[1]}};
  assign B     = {8{DEN & rgb[0]}};
`else
  assign R = 8'h00;
  assign G = 8'h00;
  assign B = 8'h00;
`endif

endmodule

// File: tb/tb_lcd_timing_gen.sv
// tb/tb_lcd_timing_gen.sv - scoreboard bench for lcd_timing_gen, arithmetic tick-count reference model
// Vertical timing is shortened so several whole frames fit in the run; horizontal timing is the real 1056.
module tb_lcd_timing_gen;
  localparam int H_ACT = 800, H_FP = 40, H_SYNC = 30, H_BP = 186;
  localparam int V_ACT = 6, V_FP = 2, V_SYNC = 2, V_BP = 2;
  localparam int PIPE  = 2;
  localparam int H_TOT = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACT + V_FP + V_SYNC + V_BP;
  localparam int FRAME = H_TOT * V_TOT;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        NCLK, GREST, PIX_TICK, SOF, HD, VD, DEN;
  logic [10:0] X;
  logic [9:0]  Y;
  logic [7:0]  R, G, B;

  lcd_timing_gen #(
    .H_ACT(H_ACT), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACT(V_ACT), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP), .PIPE(PIPE)
  ) dut (
    .CLK(CLK), .RST(RST), .NCLK(NCLK), .GREST(GREST), .PIX_TICK(PIX_TICK),
    .X(X), .Y(Y), .SOF(SOF), .HD(HD), .VD(VD), .DEN(DEN), .R(R), .G(G), .B(B)
  );

  always #10 CLK = ~CLK;

  typedef struct packed {
    logic        nclk, grest, tick, sof, hd, vd, den;
    logic [10:0] x;
    logic [9:0]  y;
    logic [7:0]  r, g, b;
  } obs_t;

  obs_t   exp_q[$];
  int     checks = 0;
  int     errors = 0;
  longint mc = 0;
  logic   m_grest = 1'b0;

`ifdef LCD_COLOR_BAR_EN
  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
`endif

  // c = CLK edges since reset release; the panel has made c/2 pixel ticks
  function automatic obs_t model(input longint c, input logic gr);
    obs_t   o;
    longint t, k;
    int     kx, ky;
    o       = '0;
    o.grest = gr;
    o.nclk  = (c % 2) == 1;
    o.tick  = o.nclk;
    t       = c / 2;
    o.x     = 11'(t % H_TOT);
    o.y     = 10'((t / H_TOT) % V_TOT);
    o.sof   = (c > 0) && (c % 2 == 0) && (t % FRAME == 0);
    o.hd    = 1'b1;
    o.vd    = 1'b1;
    o.den   = 1'b0;
    k       = t - PIPE;
    if (k >= 1) begin
      kx    = int'(k % H_TOT);
      ky    = int'((k / H_TOT) % V_TOT);
      o.hd  = !(kx >= H_ACT + H_FP && kx < H_ACT + H_FP + H_SYNC);
      o.vd  = !(ky >= V_ACT + V_FP && ky < V_ACT + V_FP + V_SYNC);
      o.den = (kx < H_ACT) && (ky < V_ACT);
`ifdef LCD_COLOR_BAR_EN
      if (o.den) {o.r, o.g, o.b} = bars[kx / 100];
`endif
    end
    return o;
  endfunction

  always @(posedge CLK) begin
    if (RST) begin
      mc      = 0;
      m_grest = 1'b0;
    end else begin
      mc      = mc + 1;
      m_grest = 1'b1;
    end
    exp_q.push_back(model(mc, m_grest));
  end

  always @(negedge CLK) begin
    obs_t e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = '{NCLK, GREST, PIX_TICK, SOF, HD, VD, DEN, X, Y, R, G, B};
      checks++;
      if (a !== e) begin
        errors++;
        if (errors <= 20)
          $display("FAIL outputs @%0t: got nclk=%b grest=%b tick=%b sof=%b hd=%b vd=%b den=%b x=%0d y=%0d rgb=%h%h%h, want nclk=%b grest=%b tick=%b sof=%b hd=%b vd=%b den=%b x=%0d y=%0d rgb=%h%h%h",
                   $time, a.nclk, a.grest, a.tick, a.sof, a.hd, a.vd, a.den, a.x, a.y, a.r, a.g, a.b,
                   e.nclk, e.grest, e.tick, e.sof, e.hd, e.vd, e.den, e.x, e.y, e.r, e.g, e.b);
      end
    end
  end

  initial begin
    RST = 1'b1;
    repeat (20) @(posedge CLK);
    #1 RST = 1'b0;
    // Two whole frames, then stop with the counters at X=400, Y=3
    repeat (2 * (2 * FRAME + 3 * H_TOT + 400)) @(posedge CLK);
    #1 RST = 1'b1;
    @(posedge CLK);
    #1 RST = 1'b0;
    repeat (3000) @(posedge CLK);
    for (int n = 0; n < 3; n++) begin
      repeat ($urandom_range(1, 4000)) @(posedge CLK);
      #1 RST = 1'b1;
      repeat ($urandom_range(1, 3)) @(posedge CLK);
      #1 RST = 1'b0;
    end
    repeat (3000) @(posedge CLK);
    @(negedge CLK);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd_timing_gen.md
Name: lcd_timing_gen

Overview:
Pixel-timing generator for the 800x480 parallel-RGB LCD panel path. It sits directly upstream of the text/pixel renderer.
- Divides the 50 MHz system clock into the panel clock NCLK.
- Produces lookahead pixel coordinates X/Y and a pixel-tick strobe for the renderer.
- Produces the panel sync/enable signals (HD, VD, DEN), delayed by PIPE pixel ticks to line up with renderer latency.

Parameters:
H_ACT, 800, active pixels per line
H_FP, 40, horizontal front porch (ticks)
H_SYNC, 30, HD low width (ticks)
H_BP, 186, horizontal back porch (ticks); line total 1056
V_ACT, 480, active lines per frame
V_FP, 22, vertical front porch (lines)
V_SYNC, 13, VD low width (lines)
V_BP, 10, vertical back porch (lines); frame total 525
PIPE, 2, renderer latency in pixel ticks applied to HD/VD/DEN (0..7)

Ports:
CLK  in  1  system clock, 50 MHz
RST  in  1  synchronous reset, active-high
NCLK  out  1  panel pixel clock, CLK/2
GREST  out  1  panel global reset, active-low
PIX_TICK  out  1  one-CLK strobe, pixel advance
X  out  11  current column counter (lookahead, undelayed)
Y  out  10  current row counter (lookahead, undelayed)
SOF  out  1  one-CLK pulse when counters wrap to (0,0)
HD  out  1  horizontal sync, active-low, delayed PIPE ticks
VD  out  1  vertical sync, active-low, delayed PIPE ticks
DEN  out  1  data enable, active-high, delayed PIPE ticks
R  out  8  colour-bar red (optional feature)
G  out  8  colour-bar green (optional feature)
B  out  8  colour-bar blue (optional feature)

Behaviour:
- All logic sits on posedge CLK. RST is sampled synchronously; no async paths.
- Reset values: NCLK=0, GREST=0, PIX_TICK=0, X=0, Y=0, SOF=0, HD=1, VD=1, DEN=0, R=G=B=0. Delay-line contents are cleared to the idle values (HD=1, VD=1, DEN=0).
- GREST is registered ~RST, so it goes 1 on the first CLK edge after RST falls.
- NCLK is a toggle flop; it toggles every CLK while RST=0.
- PIX_TICK = 1 on the CLK cycle in which NCLK is 1 (so it toggles to 0 at that edge). Counters and delay line advance only on that edge, so outputs change at NCLK falling and are stable at NCLK rising, where the panel samples.
- Horizontal counter X runs 0..1055 and wraps to 0. On wrap, Y increments and wraps 524 -> 0.
- SOF=1 for exactly the CLK cycle following the tick on which (X,Y) becomes (0,0).
- Undelayed decode (from X/Y):
  - h_act = X < H_ACT
  - hs_n = !(H_ACT+H_FP <= X < H_ACT+H_FP+H_SYNC), i.e. low for X = 840..869
  - v_act = Y < V_ACT
  - vs_n = !(V_ACT+V_FP <= Y < V_ACT+V_FP+V_SYNC), i.e. low for Y = 502..514
  - den = h_act & v_act
- Output alignment: {hs_n, vs_n, den} pass through a PIPE-deep shift register clocked by PIPE_TICK-qualified edges. With PIPE=0 they are registered once, on the same edge as X/Y.
- Frame period: 1056*525 = 554400 ticks = 1108800 CLK cycles.
- Reset mid-frame: the next edge forces all reset values and clears counters to (0,0). SOF does not pulse for this forced clear; the first SOF is at the first natural wrap.
- Counter arithmetic is unsigned. The width-11 X register covers the 1056-count line.

Optional Feature:
LCD_COLOR_BAR_EN:
- Defined: R/G/B carry 8 vertical bars, each 100 columns wide, selected on delayed X.
  - Bar order: white, yellow, cyan, green, magenta, red, blue, black.
  - Each channel is 8'hFF or 8'h00.
  - Channels are forced to 0 whenever delayed DEN=0.
  - Delayed X travels in the same PIPE delay line as the syncs.
- Undefined: R=G=B=8'h00 constant; no extra delay-line storage.

Test Plan:
- Reset held 20 CLK, then released -> during reset all outputs equal their reset values; GREST=1 one edge after release; NCLK period 40 ns (2 CLK).
- Free-run one line, PIPE=2 -> DEN high for exactly 800 consecutive ticks, rising 2 ticks after X=0; HD low 30 ticks, starting 2 ticks after X=840.
- Free-run one frame -> VD low for 13*1056 = 13728 ticks starting on row 502 (+2 ticks); DEN never high on rows 480..524.
- Two consecutive frames -> SOF pulses exactly 1108800 CLK apart, each 1 CLK wide.
- Assert RST for 1 cycle at X=400, Y=200 -> next edge X=0, Y=0, HD=VD=1, DEN=0; no SOF pulse; DEN rises again 2 ticks after release plus alignment.
- With LCD_COLOR_BAR_EN defined, sample active row 10 -> delayed columns 0..99 give RGB FF/FF/FF, 500..599 give FF/00/00, 700..799 give 00/00/00; blanking gives 0.
